// File: rtl/assoc_cache_ctrl.sv
// assoc_cache_ctrl: N-way set-associative cache with read-allocate block fill,
// write-through / no-write-allocate stores and per-set age-based LRU.
// Optional build macro CACHE_STATS_EN adds saturating hit/miss counters.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | accepting requests; read hits answered the next cycle
// FILL   | fetching the missed block word by word into the victim way
// RESP   | presenting the requested word of the freshly filled block
// WMEM   | writing the store through to memory, waiting for the ack
module assoc_cache_ctrl #(
  parameter int WAYS  = 2,
  parameter int SETS  = 64,
  parameter int WORDS = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [15:0] req_addr_i,
  input  logic [15:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic        mem_valid_i,
  input  logic [15:0] mem_rdata_i
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_count_o,
  output logic [15:0] miss_count_o
`endif
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 15 - IDX_W - OFF_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_WMEM = 2'd3;

  logic [1:0]       state_q;
  logic [15:0]      addr_q;
  logic [15:0]      wdata_q;
  logic [15:0]      rdata_q;
  logic             hit_pulse_q;
  logic [WAY_W-1:0] victim_q;
  logic [OFF_W-1:0] cnt_q;

  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic             valid_q [WAYS][SETS];
  logic [WAY_W-1:0] age_q   [WAYS][SETS];
  logic [15:0]      data_q  [WAYS][SETS][WORDS];

  logic [TAG_W-1:0] req_tag, lat_tag;
  logic [IDX_W-1:0] req_idx, lat_idx, lru_set;
  logic [OFF_W-1:0] req_word, lat_word;
  logic             accept, hit, found, last_beat, lru_en;
  logic [WAY_W-1:0] hit_way, victim, lru_way;

  assign req_tag  = req_addr_i[15 -: TAG_W];
  assign req_idx  = req_addr_i[OFF_W+IDX_W : OFF_W+1];
  assign req_word = req_addr_i[OFF_W:1];
  assign lat_tag  = addr_q[15 -: TAG_W];
  assign lat_idx  = addr_q[OFF_W+IDX_W : OFF_W+1];
  assign lat_word = addr_q[OFF_W:1];

  assign accept    = req_valid_i && (state_q == S_IDLE);
  assign last_beat = (state_q == S_FILL) && mem_valid_i && (cnt_q == OFF_W'(WORDS - 1));

  // Tag compare across the indexed set and victim choice for a miss
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    found   = 1'b0;
    victim  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!found && !valid_q[w][req_idx]) begin
        found  = 1'b1;
        victim = WAY_W'(w);
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[w][req_idx] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
      end
    end
  end

  // Select which way/set gets its LRU age refreshed this cycle
  always_comb begin
    lru_en  = (accept && hit) || last_beat;
    lru_way = accept ? hit_way : victim_q;
    lru_set = accept ? req_idx : lat_idx;
  end

  // Controller state, tag/valid/age arrays and request latches
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      hit_pulse_q <= 1'b0;
      victim_q    <= '0;
      cnt_q       <= '0;
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[w][s] <= 1'b0;
          tag_q[w][s]   <= '0;
          age_q[w][s]   <= WAY_W'(w);
        end
      end
    end else begin
      hit_pulse_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            if (req_we_i) begin
              state_q <= S_WMEM;
            end else if (hit) begin
              hit_pulse_q <= 1'b1;
              rdata_q     <= data_q[hit_way][req_idx][req_word];
            end else begin
              // the victim stays invalid until its fill completes
              victim_q                <= victim;
              valid_q[victim][req_idx] <= 1'b0;
              cnt_q                   <= '0;
              state_q                 <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (mem_valid_i) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_beat) begin
              tag_q[victim_q][lat_idx]   <= lat_tag;
              valid_q[victim_q][lat_idx] <= 1'b1;
              state_q                    <= S_RESP;
            end
          end
        end
        S_RESP: state_q <= S_IDLE;
        default: begin
          if (mem_valid_i) state_q <= S_IDLE;
        end
      endcase
      if (lru_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == lru_way)
            age_q[w][lru_set] <= '0;
          else if (age_q[w][lru_set] < age_q[lru_way][lru_set])
            age_q[w][lru_set] <= age_q[w][lru_set] + 1'b1;
        end
      end
    end
  end

  // Data array: store hits update at accept, fill beats write the victim
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (accept && req_we_i && hit)
        data_q[hit_way][req_idx][req_word] <= req_wdata_i;
      else if ((state_q == S_FILL) && mem_valid_i)
        data_q[victim_q][lat_idx][cnt_q] <= mem_rdata_i;
    end
  end

  // Request/response and memory-side outputs decoded from state
  always_comb begin
    req_ready_o = (state_q == S_IDLE);
    rsp_valid_o = hit_pulse_q || (state_q == S_RESP) || ((state_q == S_WMEM) && mem_valid_i);
    rsp_rdata_o = '0;
    if (hit_pulse_q)
      rsp_rdata_o = rdata_q;
    else if (state_q == S_RESP)
      rsp_rdata_o = data_q[victim_q][lat_idx][lat_word];
    mem_req_o   = (state_q == S_FILL) || (state_q == S_WMEM);
    mem_we_o    = (state_q == S_WMEM);
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (state_q == S_FILL) begin
      mem_addr_o = {lat_tag, lat_idx, cnt_q, 1'b0};
    end else if (state_q == S_WMEM) begin
      mem_addr_o  = addr_q & 16'hFFFE;
      mem_wdata_o = wdata_q;
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  // Saturating hit/miss counters, one step per accepted request
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accept) begin
      if (hit) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`else
  // statistics counters are not built
`endif

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed bench for assoc_cache_ctrl: default 2-way instance plus a 4-way,
// 16-set, 4-word instance. Memory returns word(a) = a ^ 0x5A5A after 2 cycles.
// Build with CACHE_STATS_EN defined to also exercise the hit/miss counters.
module tb_assoc_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [2];
  logic        req_we    [2];
  logic [15:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_rdata [2];
  logic        mem_req   [2];
  logic        mem_we    [2];
  logic [15:0] mem_addr  [2];
  logic [15:0] mem_wdata [2];
  logic        mem_valid [2];
  logic [15:0] mem_rdata [2];
  logic [15:0] hit_count [2];
  logic [15:0] miss_count[2];

  int          rd_n [2];
  int          wr_n [2];
  logic [15:0] rd_log [2][64];
  logic [15:0] wr_addr [2];
  logic [15:0] wr_data [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assoc_cache_ctrl u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[0]), .req_we_i(req_we[0]), .req_addr_i(req_addr[0]),
    .req_wdata_i(req_wdata[0]), .req_ready_o(req_ready[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rsp_rdata[0]),
    .mem_req_o(mem_req[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]),
    .mem_wdata_o(mem_wdata[0]), .mem_valid_i(mem_valid[0]), .mem_rdata_i(mem_rdata[0])
`ifdef CACHE_STATS_EN
    , .hit_count_o(hit_count[0]), .miss_count_o(miss_count[0])
`endif
  );

  assoc_cache_ctrl #(.WAYS(4), .SETS(16), .WORDS(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[1]), .req_we_i(req_we[1]), .req_addr_i(req_addr[1]),
    .req_wdata_i(req_wdata[1]), .req_ready_o(req_ready[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rsp_rdata[1]),
    .mem_req_o(mem_req[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]),
    .mem_wdata_o(mem_wdata[1]), .mem_valid_i(mem_valid[1]), .mem_rdata_i(mem_rdata[1])
`ifdef CACHE_STATS_EN
    , .hit_count_o(hit_count[1]), .miss_count_o(miss_count[1])
`endif
  );

  // Memory responders: ack every request two cycles after it is seen
  for (genvar g = 0; g < 2; g++) begin : g_mem
    initial begin
      int lat_cnt;
      lat_cnt      = 0;
      rd_n[g]      = 0;
      wr_n[g]      = 0;
      wr_addr[g]   = '0;
      wr_data[g]   = '0;
      mem_valid[g] = 1'b0;
      mem_rdata[g] = '0;
      forever begin
        @(posedge clk);
        #1;
        mem_valid[g] = 1'b0;
        if (mem_req[g]) begin
          lat_cnt++;
          if (lat_cnt >= 2) begin
            lat_cnt      = 0;
            mem_valid[g] = 1'b1;
            if (mem_we[g]) begin
              wr_n[g]++;
              wr_addr[g]   = mem_addr[g];
              wr_data[g]   = mem_wdata[g];
              mem_rdata[g] = '0;
            end else begin
              if (rd_n[g] < 64) rd_log[g][rd_n[g]] = mem_addr[g];
              rd_n[g]++;
              mem_rdata[g] = mem_addr[g] ^ 16'h5A5A;
            end
          end
        end else begin
          lat_cnt = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input int s, input logic we, input logic [15:0] addr,
                        input logic [15:0] wd, output logic [15:0] rd, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready[s] && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    req_valid[s] = 1'b1;
    req_we[s]    = we;
    req_addr[s]  = addr;
    req_wdata[s] = wd;
    @(negedge clk);
    req_valid[s] = 1'b0;
    lat = 1;
    while (!rsp_valid[s] && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_arrived", {31'd0, rsp_valid[s]}, 32'd1);
    rd = rsp_rdata[s];
  endtask

  initial begin
    logic [15:0] rd;
    int lat, base, wbase, guard;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset values
    chk("rst_ready",  {31'd0, req_ready[0]}, 32'd1);
    chk("rst_rspv",   {31'd0, rsp_valid[0]}, 32'd0);
    chk("rst_rdata",  {16'd0, rsp_rdata[0]}, 32'd0);
    chk("rst_memreq", {31'd0, mem_req[0]},   32'd0);
    chk("rst_memwe",  {31'd0, mem_we[0]},    32'd0);
    chk("rst_maddr",  {16'd0, mem_addr[0]},  32'd0);
    chk("rst_mwdata", {16'd0, mem_wdata[0]}, 32'd0);
    chk("rst_ready4", {31'd0, req_ready[1]}, 32'd1);

    // cold read miss fills 8 words at 0x0040..0x004E
    do_req(0, 1'b0, 16'h0040, 16'h0, rd, lat);
    chk("cold_rdata", {16'd0, rd}, 32'h5A1A);
    chk("cold_beats", rd_n[0], 8);
    for (int i = 0; i < 8; i++) chk("cold_addr", {16'd0, rd_log[0][i]}, 32'h40 + 32'(2 * i));
    chk("cold_lat_gt1", {31'd0, lat > 1}, 32'd1);

    do_req(0, 1'b0, 16'h0042, 16'h0, rd, lat);
    chk("hit_rdata", {16'd0, rd}, 32'h5A18);
    chk("hit_lat", lat, 1);
    chk("hit_nomem", rd_n[0], 8);

`ifdef CACHE_STATS_EN
    wbase = wr_n[0];
    do_req(0, 1'b1, 16'h0042, 16'h5A18, rd, lat);
    chk("stats_hit",  {16'd0, hit_count[0]},  32'd2);
    chk("stats_miss", {16'd0, miss_count[0]}, 32'd1);
    chk("stats_wr",   wr_n[0], wbase + 1);
`endif

    // LRU in set 0: 0x0400 block is the eviction victim
    do_req(0, 1'b0, 16'h0000, 16'h0, rd, lat);
    chk("lru_a_rdata", {16'd0, rd}, 32'h5A5A);
    do_req(0, 1'b0, 16'h0400, 16'h0, rd, lat);
    chk("lru_b_rdata", {16'd0, rd}, 32'h5E5A);
    do_req(0, 1'b0, 16'h0000, 16'h0, rd, lat);
    chk("lru_a_hit", lat, 1);
    base = rd_n[0];
    do_req(0, 1'b0, 16'h0800, 16'h0, rd, lat);
    chk("lru_c_rdata", {16'd0, rd}, 32'h525A);
    chk("lru_c_beats", rd_n[0], base + 8);
    do_req(0, 1'b0, 16'h0000, 16'h0, rd, lat);
    chk("lru_a_rehit", lat, 1);
    chk("lru_a_rdata2", {16'd0, rd}, 32'h5A5A);
    base = rd_n[0];
    do_req(0, 1'b0, 16'h0400, 16'h0, rd, lat);
    chk("lru_b_remiss", rd_n[0], base + 8);
    chk("lru_b_rdata2", {16'd0, rd}, 32'h5E5A);

    // write-through hit then readback
    wbase = wr_n[0];
    base  = rd_n[0];
    do_req(0, 1'b1, 16'h0040, 16'hBEEF, rd, lat);
    chk("wr_count", wr_n[0], wbase + 1);
    chk("wr_addr",  {16'd0, wr_addr[0]}, 32'h0040);
    chk("wr_data",  {16'd0, wr_data[0]}, 32'hBEEF);
    chk("wr_ack",   {31'd0, mem_valid[0]}, 32'd1);
    chk("wr_rdata", {16'd0, rd}, 32'd0);
    @(negedge clk);
    chk("wr_ready_after", {31'd0, req_ready[0]}, 32'd1);
    do_req(0, 1'b0, 16'h0040, 16'h0, rd, lat);
    chk("wr_readback", {16'd0, rd}, 32'hBEEF);
    chk("wr_readback_lat", lat, 1);
    chk("wr_no_reads", rd_n[0], base);

    // write miss: memory only, no allocation
    do_req(0, 1'b1, 16'h2000, 16'h1234, rd, lat);
    chk("wmiss_addr", {16'd0, wr_addr[0]}, 32'h2000);
    chk("wmiss_data", {16'd0, wr_data[0]}, 32'h1234);
    base = rd_n[0];
    do_req(0, 1'b0, 16'h2000, 16'h0, rd, lat);
    chk("wmiss_remiss", rd_n[0], base + 8);
    chk("wmiss_rdata", {16'd0, rd}, 32'h7A5A);

    // reset during a fill abandons the block
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = rd_n[0];
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 16'h0040;
    @(negedge clk);
    req_valid[0] = 1'b0;
    guard = 0;
    while (rd_n[0] < base + 3 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("mid_beats", rd_n[0], base + 3);
    chk("mid_busy", {31'd0, req_ready[0]}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_memreq", {31'd0, mem_req[0]}, 32'd0);
    chk("mid_ready",  {31'd0, req_ready[0]}, 32'd1);
    rst = 1'b0;
    base = rd_n[0];
    do_req(0, 1'b0, 16'h0040, 16'h0, rd, lat);
    chk("mid_remiss", rd_n[0], base + 8);
    chk("mid_rdata", {16'd0, rd}, 32'h5A1A);

    // 4-way, 16-set, 4-word: fifth tag in set 0 evicts the oldest block
    do_req(1, 1'b0, 16'h0000, 16'h0, rd, lat);
    do_req(1, 1'b0, 16'h0080, 16'h0, rd, lat);
    do_req(1, 1'b0, 16'h0100, 16'h0, rd, lat);
    do_req(1, 1'b0, 16'h0180, 16'h0, rd, lat);
    chk("w4_fill_beats", rd_n[1], 16);
    do_req(1, 1'b0, 16'h0200, 16'h0, rd, lat);
    chk("w4_e_beats", rd_n[1], 20);
    chk("w4_e_addr0", {16'd0, rd_log[1][16]}, 32'h0200);
    chk("w4_e_addr3", {16'd0, rd_log[1][19]}, 32'h0206);
    chk("w4_e_rdata", {16'd0, rd}, 32'h585A);
    do_req(1, 1'b0, 16'h0082, 16'h0, rd, lat);
    chk("w4_b_hit", lat, 1);
    chk("w4_b_rdata", {16'd0, rd}, 32'h5AD8);
    chk("w4_b_nomem", rd_n[1], 20);
    do_req(1, 1'b0, 16'h0000, 16'h0, rd, lat);
    chk("w4_a_remiss", rd_n[1], 24);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
